// File: rtl/cpu_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port indices
// and the port-to-one-hot helper used for the grant/done pulses.
package cpu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEF_DATA_W = 32;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that was not granted last.
module rr_pick2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            winner = (last == PORT_CPU) ? PORT_LDR : PORT_CPU;
        end else begin
            winner = req[PORT_LDR];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (port 0)
// and the loader/debug port (port 1), one transaction at a time with timeout.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic pick_valid;
    logic pick_port;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_reg),
        .valid  (pick_valid),
        .winner (pick_port)
    );

    // last_reg doubles as the owner of the in-flight transaction, since it is
    // updated at the grant edge and only changes again at the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_reg      <= PORT_LDR;
            gnt_reg       <= '0;
            done_reg      <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_reg       <= port_onehot(pick_port);
                        last_reg      <= pick_port;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= we[pick_port];
                        mem_addr_reg  <= (pick_port == PORT_LDR) ? addr1 : addr0;
                        mem_wdata_reg <= (pick_port == PORT_LDR) ? wdata1 : wdata0;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        if (!mem_we_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                        err_reg     <= 1'b0;
                        done_reg    <= port_onehot(last_reg);
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        rdata_reg   <= '0;
                        err_reg     <= 1'b1;
                        done_reg    <= port_onehot(last_reg);
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// transactions against a round-robin/memory reference model.
module tb_dmem_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        gnt, done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory environment controls (written only by the main initial block).
    int ack_delay = 0;
    int stray_req = 0;

    // Reference model state.
    int          m_last;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'd100;
        return (32'(i) * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int exp_winner(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last == 0) ? 1 : 0;
    endfunction

    // Memory responder: acks ack_delay cycles into each request, 0/neg = never.
    logic [31:0] mem_arr [1024];
    initial begin
        int ack_cnt;
        int stray_served;
        ack_cnt = 0;
        stray_served = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);
        forever begin
            @(posedge clk);
            #2;
            if (!mem_req) begin
                ack_cnt = 0;
                mem_ack = 1'b0;
                if (stray_req != stray_served) begin
                    mem_ack = 1'b1;
                    mem_rdata = $urandom;
                    stray_served++;
                end
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else begin
                ack_cnt++;
                if (ack_cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_rdata = $urandom;
                        mem_arr[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
        we[p] = w;
        if (p == 0) begin
            addr0 = a;
            wdata0 = d;
        end else begin
            addr1 = a;
            wdata1 = d;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_rdata"}, 64'(rdata), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    // One complete transaction from the currently driven req pattern.
    // Returns sampled in the done (RESP) cycle.
    task automatic one_txn(input int exp_lat, input int delay, input bit drop_after_gnt,
                           input bit keep_req, input int new_addr);
        int w, lat, rc, exp_rc;
        bit ew, succ;
        logic [9:0] ea;
        logic [31:0] ed;
        w = exp_winner(req, m_last);
        ack_delay = delay;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            chk("no_done_before_gnt", 64'(done), 64'(0));
        end while (gnt === 2'b00 && lat < 6);
        if (exp_lat > 0) chk("gnt_latency", 64'(lat), 64'(exp_lat));
        chk("gnt", 64'(gnt), 64'(oh(w)));
        ew = we[w];
        ea = (w == 1) ? addr1 : addr0;
        ed = (w == 1) ? wdata1 : wdata0;
        chk("mem_req_on", 64'(mem_req), 64'(1));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_we", 64'(mem_we), 64'(ew));
        if (ew) chk("mem_wdata", 64'(mem_wdata), 64'(ed));
        set_port(w, 1'($urandom), (new_addr >= 0) ? 10'(new_addr) : 10'($urandom), $urandom);
        if (drop_after_gnt) req[w] = 1'b0;
        rc = 1;
        for (int i = 0; i < TIMEOUT + 6; i++) begin
            @(posedge clk);
            #1;
            if (done !== 2'b00) break;
            rc++;
            chk("wait_gnt_low", 64'(gnt), 64'(0));
            chk("mem_req_hold", 64'(mem_req), 64'(1));
            chk("mem_addr_hold", 64'(mem_addr), 64'(ea));
            chk("mem_we_hold", 64'(mem_we), 64'(ew));
        end
        succ = (delay >= 1 && delay <= TIMEOUT);
        exp_rc = succ ? delay : TIMEOUT;
        chk("req_cycles", 64'(rc), 64'(exp_rc));
        chk("done", 64'(done), 64'(oh(w)));
        chk("done_gnt_low", 64'(gnt), 64'(0));
        chk("resp_mem_req", 64'(mem_req), 64'(0));
        if (!succ) m_rdata = 32'd0;
        else if (ew) ref_mem[ea] = ed;
        else m_rdata = ref_mem[ea];
        chk("err", 64'(err), 64'(!succ));
        chk("rdata", 64'(rdata), 64'(m_rdata));
        m_last = w;
        if (!keep_req) req[w] = 1'b0;
        $display("txn port=%0d we=%0d addr=%0d wait=%0d rdata=%0h err=%0d", w, ew, ea, rc, rdata, err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        m_last = 1;
        m_rdata = 32'd0;
    endtask

    initial begin
        reset = 1'b0;
        req = 2'b00;
        we = 2'b00;
        addr0 = '0;
        addr1 = '0;
        wdata0 = '0;
        wdata1 = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        m_last = 1;
        m_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Single CPU read of word 1, ack two cycles into WAIT.
        set_port(0, 1'b0, 10'd1, 32'd0);
        req = 2'b01;
        one_txn(1, 2, 1'b0, 1'b0, -1);

        // Loader writes 15 to word 2, CPU reads it back.
        set_port(1, 1'b1, 10'd2, 32'd15);
        req = 2'b10;
        one_txn(2, int'($urandom_range(1, 4)), 1'b0, 1'b0, -1);
        set_port(0, 1'b0, 10'd2, 32'd0);
        req = 2'b01;
        one_txn(2, int'($urandom_range(1, 4)), 1'b0, 1'b0, -1);
        chk("ldr_write_readback", 64'(rdata), 64'(15));

        // Continuous tie after reset: grants alternate starting with the CPU.
        do_reset();
        set_port(0, 1'($urandom), 10'($urandom), $urandom);
        set_port(1, 1'($urandom), 10'($urandom), $urandom);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            one_txn((k == 0) ? 1 : 2, int'($urandom_range(1, 5)), 1'b0, k < 3, -1);
            chk("tie_order", 64'(m_last), 64'(k % 2));
        end
        req = 2'b00;

        // Timeout on a CPU read, then a normal loader read.
        set_port(0, 1'b0, 10'($urandom), 32'd0);
        req = 2'b01;
        one_txn(2, -1, 1'b0, 1'b0, -1);
        set_port(1, 1'b0, 10'($urandom), 32'd0);
        req = 2'b10;
        one_txn(2, 3, 1'b0, 1'b0, -1);

        // Stray ack while idle must be ignored.
        stray_req++;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("stray_gnt", 64'(gnt), 64'(0));
            chk("stray_done", 64'(done), 64'(0));
            chk("stray_rdata", 64'(rdata), 64'(m_rdata));
        end

        // Command stability: CPU moves addr0 3 -> 7 and drops req after grant.
        set_port(0, 1'b0, 10'd3, 32'd0);
        req = 2'b01;
        one_txn(1, 4, 1'b1, 1'b0, 7);

        // Reset in the middle of a loader WAIT.
        set_port(1, 1'b0, 10'd5, 32'd0);
        req = 2'b10;
        ack_delay = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pre_gnt", 64'(gnt), 64'(2'b10));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        req = 2'b00;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", 64'(done), 64'(0));
        end
        @(negedge clk);
        reset = 1'b1;
        m_last = 1;
        m_rdata = 32'd0;
        set_port(0, 1'($urandom), 10'($urandom), $urandom);
        set_port(1, 1'($urandom), 10'($urandom), $urandom);
        req = 2'b11;
        one_txn(1, 2, 1'b0, 1'b0, -1);
        chk("post_reset_cpu_first", 64'(m_last), 64'(0));
        req = 2'b00;

        // Random mix of patterns, commands and ack delays (some time out).
        for (int k = 0; k < 30; k++) begin
            set_port(0, 1'($urandom), 10'($urandom_range(0, 15)), $urandom);
            set_port(1, 1'($urandom), 10'($urandom_range(0, 15)), $urandom);
            req = 2'($urandom_range(1, 3));
            one_txn(2, int'($urandom_range(1, TIMEOUT + 2)), 1'($urandom), 1'b0, -1);
            req = 2'b00;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
